// File: rtl/store_write_buffer.sv
// In-order store write buffer: DEPTH-entry FIFO draining to memory, with a
// combinational load-overlap query. Optional store-to-load forwarding: STORE_BUFFER_FORWARD_EN.
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_type,
    input  logic [63:0] st_data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_type,
    output logic [63:0] mem_data,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_type,
    output logic        ld_dep,
    output logic        ld_fwd_hit,
    output logic [63:0] ld_fwd_data,
    output logic        empty,
    output logic        full,
    output logic [3:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      addr_q [DEPTH];
    logic [1:0]       type_q [DEPTH];
    logic [63:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [3:0]       count_q, count_d;
    logic             enq, ret;

    // Exclusive end of a byte range, one bit wider so the top of memory never wraps.
    function automatic logic [32:0] range_end(input logic [31:0] a, input logic [1:0] t);
        return {1'b0, a} + (33'd1 << t);
    endfunction

    function automatic logic overlaps(input logic [31:0] e_addr, input logic [1:0] e_type,
                                      input logic [31:0] q_addr, input logic [32:0] q_end);
        logic [32:0] e_end;
        e_end = range_end(e_addr, e_type);
        return (q_addr == e_addr)
            || (e_addr > q_addr && q_end > {1'b0, e_addr})
            || (q_addr > e_addr && e_end > {1'b0, q_addr});
    endfunction

    assign empty    = (count_q == 4'd0);
    assign full     = (count_q == 4'(DEPTH));
    assign count    = count_q;
    assign st_ready = ~full;
    assign mem_req  = ~empty;
    assign mem_addr = addr_q[head_q];
    assign mem_type = type_q[head_q];
    assign mem_data = data_q[head_q];

    // A full buffer refuses stores even when the head retires this same cycle.
    assign enq = st_valid & ~full;
    assign ret = mem_ack & ~empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) tail_d = tail_q + PTR_W'(1);
        if (ret) head_d = head_q + PTR_W'(1);
        case ({enq, ret})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset; an entry is meaningful only while count covers it.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr;
            type_q[tail_q] <= st_type;
            data_q[tail_q] <= st_data;
        end
    end

    // Walk entries oldest to youngest so the last overlap seen is the youngest one.
    logic [32:0]      ld_end;
    logic [PTR_W-1:0] idx;
    logic             ovl_any;
`ifdef STORE_BUFFER_FORWARD_EN
    logic [PTR_W-1:0] yng_idx;
`endif

    always_comb begin
        ld_end  = range_end(ld_addr, ld_type);
        ovl_any = 1'b0;
        idx     = head_q;
`ifdef STORE_BUFFER_FORWARD_EN
        yng_idx = head_q;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (4'(i) < count_q && overlaps(addr_q[idx], type_q[idx], ld_addr, ld_end)) begin
                ovl_any = 1'b1;
`ifdef STORE_BUFFER_FORWARD_EN
                yng_idx = idx;
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FORWARD_EN
    logic fwd_ok;

    always_comb begin
        fwd_ok      = ovl_any && (addr_q[yng_idx] == ld_addr) && (type_q[yng_idx] >= ld_type);
        ld_fwd_hit  = fwd_ok;
        ld_dep      = ovl_any & ~fwd_ok;
        ld_fwd_data = '0;
        if (fwd_ok) begin
            case (ld_type)
                2'd0:    ld_fwd_data = {56'd0, data_q[yng_idx][7:0]};
                2'd1:    ld_fwd_data = {48'd0, data_q[yng_idx][15:0]};
                2'd2:    ld_fwd_data = {32'd0, data_q[yng_idx][31:0]};
                default: ld_fwd_data = data_q[yng_idx];
            endcase
        end
    end
`else
    assign ld_dep      = ovl_any;
    assign ld_fwd_hit  = 1'b0;
    assign ld_fwd_data = '0;
`endif

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending store entries (power of two, 2..8).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports st_valid in 1 / st_ready out 1  store enqueue handshake.
REQ-005 SHALL have ports st_addr in 32 / st_type in 2 / st_data in 64  store address, size code, data (low bytes significant).
REQ-006 SHALL have ports mem_req out 1 / mem_ack in 1  drain handshake to memory.
REQ-007 SHALL have ports mem_addr out 32 / mem_type out 2 / mem_data out 64  oldest entry contents.
REQ-008 SHALL have ports ld_addr in 32 / ld_type in 2  load query.
REQ-009 SHALL have ports ld_dep out 1 / ld_fwd_hit out 1 / ld_fwd_data out 64  query result.
REQ-010 SHALL have ports empty out 1 / full out 1 / count out 4  occupancy.

Function
REQ-011 SHALL decode size code 0/1/2/3 as 1/2/4/8 bytes; range is half-open [addr, addr+size), end computed in 33 bits (no wrap).
REQ-012 SHALL operate as in-order FIFO of DEPTH entries {addr, type, data}, circular head/tail pointers.
REQ-013 SHALL drive st_ready = ~full; enqueue occurs on cycle with st_valid && st_ready.
REQ-014 SHALL NOT enqueue when full, even if a drain retires the same cycle.
REQ-015 SHALL drive mem_req = ~empty; mem_addr/type/data = head entry, stable until retired.
REQ-016 SHALL retire head on cycle with mem_req && mem_ack; mem_ack while empty is ignored.
REQ-017 SHALL allow simultaneous enqueue and retire; count unchanged, both pointers advance, pointers wrap modulo DEPTH.
REQ-018 SHALL compute query combinationally over entries valid at start of cycle: same-cycle enqueue invisible, same-cycle retiring entry still visible.
REQ-019 SHALL flag entry overlap when (ld_addr == e.addr) || (e.addr > ld_addr && ld_end > e.addr) || (ld_addr > e.addr && e_end > ld_addr).
REQ-020 SHALL drive ld_dep = 1 when any valid entry overlaps and no forward hit (REQ-024) applies.
REQ-021 SHALL drive ld_fwd_hit = 0 and ld_fwd_data = 0 when REQ-024 does not apply.
REQ-022 SHALL drive empty = (count==0), full = (count==DEPTH), count = 0..DEPTH.

Reset
REQ-023 SHALL, on clk edge with reset high: count=0, pointers=0, all entries invalid; thus st_ready=1, mem_req=0, empty=1, full=0, ld_dep=0, ld_fwd_hit=0; pending enqueue/retire that cycle discarded; entry data need not be cleared.

Configuration
REQ-024 SHALL, with macro STORE_BUFFER_FORWARD_EN defined: when the youngest overlapping entry has e.addr == ld_addr and e.type >= ld_type, drive ld_fwd_hit=1, ld_dep=0, ld_fwd_data = that entry's low (1<<ld_type) bytes zero-extended.
REQ-025 SHALL, without STORE_BUFFER_FORWARD_EN: ld_fwd_hit and ld_fwd_data constant 0; every overlap raises ld_dep; no forwarding logic present.

Verification
REQ-026 Reset then enqueue 4 stores, mem_ack low -> full=1, st_ready=0, count=4, mem_addr = first store's address; 5th st_valid not accepted.
REQ-027 Full buffer, st_valid=1 and mem_ack=1 same cycle -> head retires, new store not accepted, count=3 next cycle.
REQ-028 Entry {0x4000, type 3}; query ld_addr 0x4006 type 0 -> ld_dep=1; query 0x4008 type 0 -> ld_dep=0; query 0x3FFF type 1 -> ld_dep=1.
REQ-029 With STORE_BUFFER_FORWARD_EN: entries {0x100,type2,data 0x11223344} then {0x100,type2,0xAABBCCDD}; query 0x100 type 1 -> ld_fwd_hit=1, ld_fwd_data=0xCCDD, ld_dep=0; query 0x102 type 0 -> ld_dep=1. Without macro -> ld_dep=1, ld_fwd_hit=0 for both.
REQ-030 Enqueue 9 stores interleaved with acks (pointer wrap) -> drained in enqueue order; reset asserted with 2 entries pending -> next cycle empty=1, mem_req=0.
